// File: rtl/butterfly_div_pkg.sv
// Shared definitions for the butterfly iterative divider: state encoding, default sizes
// and the quotient pattern reported on divide-by-zero.
package butterfly_div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      FIXUP = 2'd3
   } div_state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CNT_W = 5;

   // Wide enough for any supported WIDTH; the divider slices off the low WIDTH bits.
   localparam logic [63:0] DIV0_ALL_ONES = '1;

endpackage

// File: rtl/butterfly_div_trial_sub.sv
// Combinational W-bit trial subtractor (minuend - subtrahend) built from 4-bit
// carry-lookahead groups; borrow is the inverted final carry.
module butterfly_div_trial_sub
   import butterfly_div_pkg::*;
#(
   parameter int W = DEF_WIDTH + 1
) (
   input  logic [W-1:0] minuend,
   input  logic [W-1:0] subtrahend,
   output logic [W-1:0] difference,
   output logic         borrow
);

   localparam int NG = (W + 3) / 4;
   localparam int PW = NG * 4;

   // Sum-of-products lookahead carry into bit n of a 4-bit group.
   function automatic logic cla_carry(input logic [3:0] g, input logic [3:0] p,
                                      input logic cin, input int n);
      logic c;
      logic chain;
      c = 1'b0;
      for (int i = 0; i < n; i++) begin
         chain = g[i];
         for (int m = i + 1; m < n; m++) chain = chain & p[m];
         c = c | chain;
      end
      chain = cin;
      for (int m = 0; m < n; m++) chain = chain & p[m];
      return c | chain;
   endfunction

   logic [PW-1:0] a_ext;
   logic [PW-1:0] b_inv;
   logic [PW-1:0] gen;
   logic [PW-1:0] prop;
   logic [NG:0]   group_carry;

   // Padding bits propagate (a=0, ~b=1) so the top carry passes straight through them.
   assign a_ext          = PW'(minuend);
   assign b_inv          = ~PW'(subtrahend);
   assign gen            = a_ext & b_inv;
   assign prop           = a_ext ^ b_inv;
   assign group_carry[0] = 1'b1;

   for (genvar k = 0; k < NG; k++) begin : g_group
      logic [3:0] gg;
      logic [3:0] pp;
      assign gg                 = gen[4*k +: 4];
      assign pp                 = prop[4*k +: 4];
      assign group_carry[k + 1] = cla_carry(gg, pp, group_carry[k], 4);
      for (genvar j = 0; j < 4; j++) begin : g_bit
         if (4 * k + j < W) begin : g_real
            assign difference[4*k + j] = pp[j] ^ cla_carry(gg, pp, group_carry[k], j);
         end
      end
   end

   assign borrow = ~group_carry[NG];

endmodule

// File: rtl/butterfly_div16_seq.sv
// Iterative radix-2 restoring divider, one trial subtraction per clock.
// Define BUTTERFLY_DIV_SIGNED_EN for two's-complement operands (adds a FIXUP state).
module butterfly_div16_seq
   import butterfly_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_t       state;
   div_state_t       state_next;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   trial_diff;
   logic             trial_borrow;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;
   logic             last_iter;
   logic             divisor_zero;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic             unused_diff_msb;

`ifdef BUTTERFLY_DIV_SIGNED_EN
   logic q_neg;
   logic r_neg;
   assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
   assign dividend_mag = dividend;
   assign divisor_mag  = divisor;
`endif

   // After each restore step R < divisor, so the stored partial remainder never needs
   // its top bit; the WIDTH+1-bit value only exists on the shifted trial operand.
   assign r_shift         = {r_reg, q_reg[WIDTH-1]};
   assign r_next          = trial_borrow ? r_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];
   assign q_next          = {q_reg[WIDTH-2:0], ~trial_borrow};
   assign unused_diff_msb = trial_diff[WIDTH];
   assign last_iter       = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
   assign divisor_zero    = (divisor == '0);
   assign busy            = (state != IDLE);
   assign done            = (state == DONE);

   butterfly_div_trial_sub #(
      .W(WIDTH + 1)
   ) u_trial_sub (
      .minuend    (r_shift),
      .subtrahend ({1'b0, d_reg}),
      .difference (trial_diff),
      .borrow     (trial_borrow)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = divisor_zero ? DONE : RUN;
`ifdef BUTTERFLY_DIV_SIGNED_EN
         RUN:     if (last_iter) state_next = FIXUP;
         FIXUP:   state_next = DONE;
`else
         RUN:     if (last_iter) state_next = DONE;
`endif
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, shift/subtract iteration and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg       <= '0;
         r_reg       <= '0;
         d_reg       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef BUTTERFLY_DIV_SIGNED_EN
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  r_reg       <= '0;
                  q_reg       <= dividend_mag;
                  d_reg       <= divisor_mag;
                  cnt         <= '0;
                  div_by_zero <= 1'b0;
`ifdef BUTTERFLY_DIV_SIGNED_EN
                  q_neg       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_neg       <= dividend[WIDTH-1];
`endif
                  if (divisor_zero) begin
                     quotient    <= DIV0_ALL_ONES[WIDTH-1:0];
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_reg <= r_next;
               q_reg <= q_next;
               cnt   <= cnt + 1'b1;
               if (last_iter) begin
                  quotient  <= q_next;
                  remainder <= r_next;
               end
            end
`ifdef BUTTERFLY_DIV_SIGNED_EN
            FIXUP: begin
               if (q_neg) quotient  <= -quotient;
               if (r_neg) remainder <= -remainder;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_butterfly_div16_seq.sv
// Scoreboard bench for butterfly_div16_seq: expected results are pushed at each accept
// and a monitor checks them on every done pulse. Honours BUTTERFLY_DIV_SIGNED_EN.
module tb_butterfly_div16_seq;

   localparam int WIDTH = 16;
`ifdef BUTTERFLY_DIV_SIGNED_EN
   localparam int RUN_LAT = WIDTH + 2;
`else
   localparam int RUN_LAT = WIDTH + 1;
`endif

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      int          start_cyc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] last_q = '0;
   logic [15:0] last_r = '0;

   butterfly_div16_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: plain arithmetic on the operands.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int sc);
      exp_t e;
`ifdef BUTTERFLY_DIV_SIGNED_EN
      int sa;
      int sb;
`endif
      e.start_cyc = sc;
      if (b == 16'd0) begin
         e.q   = 16'hFFFF;
         e.r   = a;
         e.dbz = 1'b1;
         e.lat = 1;
      end else begin
`ifdef BUTTERFLY_DIV_SIGNED_EN
         sa  = int'($signed(a));
         sb  = int'($signed(b));
         e.q = 16'(sa / sb);
         e.r = 16'(sa % sb);
`else
         e.q = a / b;
         e.r = a % b;
`endif
         e.dbz = 1'b0;
         e.lat = RUN_LAT;
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   // Drives one start pulse and records the expected response.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      exp_q.push_back(model(a, b, cyc));
      @(posedge clk); #1;
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drained", 32'(exp_q.size()) + 32'(busy), 32'd0);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("quotient", 32'(quotient), 32'(e.q));
            checkOutput("remainder", 32'(remainder), 32'(e.r));
            checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            checkOutput("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            last_q = e.q;
            last_r = e.r;
         end
      end
   end

   initial begin
      int n;
      logic [15:0] a;
      logic [15:0] b;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("reset_quotient", 32'(quotient), 32'd0);
      checkOutput("reset_remainder", 32'(remainder), 32'd0);
      checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);

      applyStimulus(16'd100, 16'd7);
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      waitIdle(40);

      applyStimulus(16'hFFFF, 16'h0001); waitIdle(40);
      applyStimulus(16'h0005, 16'hFFFF); waitIdle(40);
      applyStimulus(16'h0000, 16'h0003); waitIdle(40);
      applyStimulus(16'h1234, 16'h0000); waitIdle(40);
      applyStimulus(16'd9, 16'd3);       waitIdle(40);

      // Start while busy must be ignored.
      applyStimulus(16'd1000, 16'd3);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("busy_during_run", 32'(busy), 32'd1);
      waitIdle(40);

      // Start pulsed in the DONE cycle must be ignored; outputs then hold.
      applyStimulus(16'd7, 16'd2);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("done_seen", 32'(done), 32'd1);
      start = 1'b1; dividend = 16'd40; divisor = 16'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
      checkOutput("hold_quotient", 32'(quotient), 32'(last_q));
      checkOutput("hold_remainder", 32'(remainder), 32'(last_r));

      // Reset in the middle of a run abandons it silently.
      applyStimulus(16'd1000, 16'd3);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_done", 32'(done), 32'd0);
      checkOutput("midreset_quotient", 32'(quotient), 32'd0);
      checkOutput("midreset_remainder", 32'(remainder), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(16'd20, 16'd6);
      waitIdle(40);

`ifdef BUTTERFLY_DIV_SIGNED_EN
      applyStimulus(16'hFF9C, 16'd7);    waitIdle(40);
      applyStimulus(16'd100, 16'hFFF9);  waitIdle(40);
      applyStimulus(16'h8000, 16'hFFFF); waitIdle(40);
`endif

      // Randomized back-to-back operations.
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       b = 16'd0;
            1, 2:    b = 16'($urandom_range(1, 15));
            3:       b = 16'($urandom_range(1, 255));
            default: b = 16'($urandom);
         endcase
         applyStimulus(a, b);
         waitIdle(40);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
